// File: rtl/vga_fb_arbiter_if.sv
// Bundle of display-read, host-write, RAM-port and statistics signals around vga_fb_arbiter.
// Signal names are given from the arbiter's point of view: i* flows into it, o* flows out.
interface vga_fb_arbiter_if #(
    parameter int unsigned AW    = 19,
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    // Display read side
    logic          iDisp_req;
    logic [AW-1:0] iDisp_addr;
    logic          oDisp_valid;
    logic [DW-1:0] oDisp_data;

    // Host write side
    logic          iHost_valid;
    logic [AW-1:0] iHost_addr;
    logic [DW-1:0] iHost_data;
    logic          oHost_ready;

    // Framebuffer RAM port
    logic          oMem_en;
    logic          oMem_we;
    logic [AW-1:0] oMem_addr;
    logic [DW-1:0] oMem_wdata;
    logic [DW-1:0] iMem_rdata;

    // Status
    logic [LW-1:0] oFifo_level;
    logic          iStat_clr;
    logic [15:0]   oStall_cnt;

    // Arbiter side
    modport slave (
        input  iDisp_req, iDisp_addr, iHost_valid, iHost_addr, iHost_data, iMem_rdata,
               iStat_clr,
        output oDisp_valid, oDisp_data, oHost_ready, oMem_en, oMem_we, oMem_addr,
               oMem_wdata, oFifo_level, oStall_cnt
    );

    // Environment side: pixel-address generator, host writer and RAM
    modport master (
        output iDisp_req, iDisp_addr, iHost_valid, iHost_addr, iHost_data, iMem_rdata,
               iStat_clr,
        input  oDisp_valid, oDisp_data, oHost_ready, oMem_en, oMem_we, oMem_addr,
               oMem_wdata, oFifo_level, oStall_cnt
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads always win the single RAM port, host writes wait
// in a small FIFO and drain on idle cycles. Reads that hit a queued write are forwarded from
// the FIFO so the screen never shows a pixel older than what the host has already sent.
module vga_fb_arbiter #(
    parameter int unsigned AW    = 19,
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input logic             iCLK,
    input logic             iRST_N,
    vga_fb_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    // FIFO storage is not reset; the level counter alone decides which entries are live.
    logic [AW-1:0] fifo_addr_q [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic          disp_valid_q;
    logic          fwd_hit_q, fwd_hit_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;
    logic [PW-1:0] fwd_idx;

    logic [15:0]   stall_cnt_q, stall_cnt_d;

    // FIFO status and handshake; a full FIFO refuses even when it pops this cycle.
    always_comb begin
        fifo_full  = (level_q == LW'(DEPTH));
        fifo_empty = (level_q == '0);
        push       = bus.iHost_valid && !fifo_full;
        pop        = !bus.iDisp_req && !fifo_empty;
    end

    // RAM port mux: display read first, otherwise drain the FIFO head.
    always_comb begin
        bus.oMem_en    = 1'b0;
        bus.oMem_we    = 1'b0;
        bus.oMem_addr  = fifo_addr_q[rd_ptr_q];
        bus.oMem_wdata = fifo_data_q[rd_ptr_q];
        if (bus.iDisp_req) begin
            bus.oMem_en   = 1'b1;
            bus.oMem_addr = bus.iDisp_addr;
        end else if (!fifo_empty) begin
            bus.oMem_en = 1'b1;
            bus.oMem_we = 1'b1;
        end
    end

    // Pointer and level next state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Forwarding search over entries queued before this cycle, oldest to youngest, so the
    // youngest match overrides. A same-cycle push is deliberately not visible here.
    always_comb begin
        fwd_hit_d  = 1'b0;
        fwd_data_d = '0;
        fwd_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if ((LW'(k) < level_q) && (fifo_addr_q[fwd_idx] == bus.iDisp_addr)) begin
                fwd_hit_d  = bus.iDisp_req;
                fwd_data_d = fifo_data_q[fwd_idx];
            end
        end
    end

    // Stall counter next state: clear wins, otherwise saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.iStat_clr) begin
            stall_cnt_d = '0;
        end else if (bus.iHost_valid && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // FIFO payload write on push.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.iHost_addr;
            fifo_data_q[wr_ptr_q] <= bus.iHost_data;
        end
    end

    // Control state registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            disp_valid_q <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            disp_valid_q <= bus.iDisp_req;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Output assignments; read data comes from the RAM unless a queued write was forwarded.
    always_comb begin
        bus.oDisp_valid = disp_valid_q;
        bus.oDisp_data  = fwd_hit_q ? fwd_data_q : bus.iMem_rdata;
        bus.oHost_ready = !fifo_full;
        bus.oFifo_level = level_q;
        bus.oStall_cnt  = stall_cnt_q;
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a behavioural RAM, a queue-based reference model
// of the arbiter, directed scenarios and a randomized traffic run.
module tb_vga_fb_arbiter;
    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk;
    logic rst_n;

    vga_fb_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    vga_fb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM driven by the DUT's port.
    bit [DW-1:0] ram [bit [AW-1:0]];
    always @(posedge clk) begin
        if (bus.oMem_en) begin
            if (bus.oMem_we) ram[bus.oMem_addr] = bus.oMem_wdata;
            else bus.iMem_rdata <= ram[bus.oMem_addr];
        end
    end

    // Reference model state
    wr_t         m_q[$];
    bit [DW-1:0] m_mem [bit [AW-1:0]];
    logic [15:0] m_stall;
    logic        exp_dv;
    logic [DW-1:0] exp_dd;

    int n_cmp;
    int n_fail;

    task automatic drive(input logic disp, input logic [AW-1:0] daddr, input logic hv,
                         input logic [AW-1:0] haddr, input logic [DW-1:0] hdata,
                         input logic clr);
        bus.iDisp_req   = disp;
        bus.iDisp_addr  = daddr;
        bus.iHost_valid = hv;
        bus.iHost_addr  = haddr;
        bus.iHost_data  = hdata;
        bus.iStat_clr   = clr;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram[a]   = d;
        m_mem[a] = d;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_stall = '0;
        exp_dv  = 1'b0;
        exp_dd  = '0;
    endtask

    // One clock cycle: compare DUT outputs against the model, then advance both.
    task automatic step();
        logic          e_en, e_we, e_rdy, n_dv;
        logic [DW-1:0] n_dd;
        logic [LW-1:0] e_lvl;
        logic          do_push;
        wr_t           w;
        #1;
        e_en  = bus.iDisp_req || (m_q.size() != 0);
        e_we  = !bus.iDisp_req && (m_q.size() != 0);
        e_rdy = (m_q.size() < DEPTH);
        e_lvl = LW'(m_q.size());
        n_cmp++;
        if (bus.oMem_en !== e_en || bus.oMem_we !== e_we) begin
            n_fail++;
            $display("FAIL mem_ctl t=%0t en/we got %b%b want %b%b", $time, bus.oMem_en,
                     bus.oMem_we, e_en, e_we);
        end
        if (bus.iDisp_req) begin
            n_cmp++;
            if (bus.oMem_addr !== bus.iDisp_addr) begin
                n_fail++;
                $display("FAIL rd_addr t=%0t got %h want %h", $time, bus.oMem_addr,
                         bus.iDisp_addr);
            end
        end else if (m_q.size() != 0) begin
            n_cmp++;
            if (bus.oMem_addr !== m_q[0].a || bus.oMem_wdata !== m_q[0].d) begin
                n_fail++;
                $display("FAIL wr_port t=%0t got %h/%h want %h/%h", $time, bus.oMem_addr,
                         bus.oMem_wdata, m_q[0].a, m_q[0].d);
            end
        end
        n_cmp++;
        if (bus.oHost_ready !== e_rdy || bus.oFifo_level !== e_lvl) begin
            n_fail++;
            $display("FAIL fifo_stat t=%0t ready/level got %b/%0d want %b/%0d", $time,
                     bus.oHost_ready, bus.oFifo_level, e_rdy, e_lvl);
        end
        n_cmp++;
        if (bus.oStall_cnt !== m_stall) begin
            n_fail++;
            $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, bus.oStall_cnt, m_stall);
        end
        n_cmp++;
        if (bus.oDisp_valid !== exp_dv || (exp_dv && bus.oDisp_data !== exp_dd)) begin
            n_fail++;
            $display("FAIL disp_rd t=%0t valid/data got %b/%h want %b/%h", $time,
                     bus.oDisp_valid, bus.oDisp_data, exp_dv, exp_dd);
        end
        // Expected read result: youngest queued write to that address, else memory.
        n_dv = bus.iDisp_req;
        n_dd = '0;
        if (n_dv) begin
            n_dd = m_mem[bus.iDisp_addr];
            foreach (m_q[i]) if (m_q[i].a == bus.iDisp_addr) n_dd = m_q[i].d;
        end
        do_push = bus.iHost_valid && (m_q.size() < DEPTH);
        w.a = bus.iHost_addr;
        w.d = bus.iHost_data;
        if (bus.iStat_clr) m_stall = '0;
        else if (bus.iHost_valid && m_q.size() >= DEPTH && m_stall != 16'hFFFF) m_stall++;
        @(posedge clk);
        if (!bus.iDisp_req && m_q.size() != 0) begin
            m_mem[m_q[0].a] = m_q[0].d;
            void'(m_q.pop_front());
        end
        if (do_push) m_q.push_back(w);
        exp_dv = n_dv;
        exp_dd = n_dd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
        #1;
        n_cmp++;
        if (bus.oDisp_valid !== 1'b0 || bus.oFifo_level !== '0 || bus.oHost_ready !== 1'b1 ||
            bus.oStall_cnt !== 16'd0 || bus.oMem_en !== 1'b0 || bus.oMem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals got v=%b lvl=%0d rdy=%b st=%0d en=%b we=%b want 0 0 1 0 0 0",
                     bus.oDisp_valid, bus.oFifo_level, bus.oHost_ready, bus.oStall_cnt,
                     bus.oMem_en, bus.oMem_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_idle_drain();
        drive(1'b0, '0, 1'b1, 19'h10, 10'h3FF, 1'b0); step();
        drive(1'b0, '0, 1'b1, 19'h11, 10'h155, 1'b0); step();
        drive(1'b0, '0, 1'b1, 19'h12, 10'h2AA, 1'b0); step();
        idle(4);
        n_cmp++;
        if (ram[19'h10] !== 10'h3FF || ram[19'h11] !== 10'h155 || ram[19'h12] !== 10'h2AA) begin
            n_fail++;
            $display("FAIL idle_drain ram got %h %h %h want 3ff 155 2aa", ram[19'h10],
                     ram[19'h11], ram[19'h12]);
        end
    endtask

    task automatic test_full_stall();
        int idx = 0;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1); step();
        for (int c = 0; c < 40 && (idx < 6 || m_q.size() != 0); c++) begin
            logic acc;
            drive(c < 12, 19'h300, idx < 6, AW'(19'h40 + idx), DW'(10'h50 + idx), 1'b0);
            acc = (idx < 6) && (m_q.size() < DEPTH);
            if (c == 11) begin
                n_cmp++;
                if (bus.oFifo_level !== LW'(4) || bus.oHost_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_fifo level/ready got %0d/%b want 4/0",
                             bus.oFifo_level, bus.oHost_ready);
                end
            end
            step();
            if (acc) idx++;
        end
        n_cmp++;
        if (bus.oStall_cnt !== 16'd9) begin
            n_fail++;
            $display("FAIL stall_total got %0d want 9", bus.oStall_cnt);
        end
        idle(2);
    endtask

    task automatic test_forwarding();
        preload(19'h100, 10'h000);
        drive(1'b1, 19'h300, 1'b1, 19'h100, 10'h1AB, 1'b0); step();
        drive(1'b1, 19'h300, 1'b1, 19'h100, 10'h3FF, 1'b0); step();
        drive(1'b1, 19'h100, 1'b0, '0, '0, 1'b0); step();
        n_cmp++;
        if (bus.oDisp_valid !== 1'b1 || bus.oDisp_data !== 10'h3FF) begin
            n_fail++;
            $display("FAIL fwd_youngest got %b/%h want 1/3ff", bus.oDisp_valid, bus.oDisp_data);
        end
        idle(3);
        drive(1'b1, 19'h100, 1'b0, '0, '0, 1'b0); step();
        n_cmp++;
        if (bus.oDisp_data !== 10'h3FF || ram[19'h100] !== 10'h3FF) begin
            n_fail++;
            $display("FAIL fwd_after_drain got %h ram %h want 3ff", bus.oDisp_data,
                     ram[19'h100]);
        end
        idle(1);
    endtask

    task automatic test_same_cycle();
        preload(19'h200, 10'h001);
        drive(1'b1, 19'h200, 1'b1, 19'h200, 10'h0F0, 1'b0); step();
        n_cmp++;
        if (bus.oDisp_data !== 10'h001) begin
            n_fail++;
            $display("FAIL same_cycle_push got %h want 001", bus.oDisp_data);
        end
        drive(1'b1, 19'h200, 1'b0, '0, '0, 1'b0); step();
        n_cmp++;
        if (bus.oDisp_data !== 10'h0F0) begin
            n_fail++;
            $display("FAIL next_read_fwd got %h want 0f0", bus.oDisp_data);
        end
        idle(3);
    endtask

    task automatic test_counter_sat();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1); step();
        for (int i = 0; i < 65540 + DEPTH; i++) begin
            drive(1'b1, 19'h7, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
            step();
        end
        n_cmp++;
        if (bus.oStall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_sat got %h want ffff", bus.oStall_cnt);
        end
        drive(1'b1, 19'h7, 1'b1, 19'h1, 10'h1, 1'b1); step();
        n_cmp++;
        if (bus.oStall_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL stall_clr got %h want 0000", bus.oStall_cnt);
        end
        drive(1'b1, 19'h7, 1'b1, 19'h1, 10'h1, 1'b0); step();
        idle(DEPTH + 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 55, AW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 60, AW'($urandom_range(0, 15)), DW'($urandom),
                  $urandom_range(0, 99) < 3);
            step();
        end
        idle(DEPTH + 2);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, AW'(i), 1'b1, AW'(19'h20 + i), DW'($urandom), 1'b0);
            step();
        end
        drive(1'b1, 19'h3, 1'b1, 19'h30, 10'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.oDisp_valid !== 1'b0 || bus.oFifo_level !== '0 || bus.oHost_ready !== 1'b1 ||
            bus.oStall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b lvl=%0d rdy=%b st=%0d want 0 0 1 0",
                     bus.oDisp_valid, bus.oFifo_level, bus.oHost_ready, bus.oStall_cnt);
        end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3);
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        n_cmp  = 0;
        n_fail = 0;
        bus.iMem_rdata = '0;
        model_reset();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        test_idle_drain();
        test_full_stall();
        test_forwarding();
        test_same_cycle();
        test_random();
        test_counter_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
